fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage for the pipelined core: owns the fetch PC, issues requests to instruction memory over a valid/ready request channel with a variable-latency response, and drives the IF/ID pipeline register. It is the consumer of the hazard unit's `StallFetch`, `StallDecode`, `FlushDecode` and `PCSrcE`. It absorbs memory latency, stalls and redirects without delivering a wrong-path instruction to decode.

## Interface
- `ADDRESS_WIDTH`, 32, PC / memory address width
- `DATA_WIDTH`, 32, instruction width
- `RESET_PC`, 32'h0000_0000, PC after reset

- `clk`  in  1  clock; all state changes on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `StallFetch`  in  1  hold fetch PC
- `StallDecode`  in  1  hold IF/ID register
- `FlushDecode`  in  1  bubble IF/ID register
- `PCSrcE`  in  1  redirect taken in execute
- `PCTargetE`  in  ADDRESS_WIDTH  redirect target
- `imem_req_valid`  out  1  request valid
- `imem_req_addr`  out  ADDRESS_WIDTH  request address
- `imem_req_ready`  in  1  memory accepts request
- `imem_resp_valid`  in  1  response valid; in order; at least 1 cycle after acceptance
- `imem_resp_data`  in  DATA_WIDTH  fetched instruction
- `InstrD`  out  DATA_WIDTH  instruction to decode
- `PCD`  out  ADDRESS_WIDTH  PC of `InstrD`
- `PCPlus4D`  out  ADDRESS_WIDTH  `PCD` + 4
- `ValidD`  out  1  `InstrD` is a real instruction

## Operation
- Registers:
  - `PCF`
  - state: IDLE / WAIT / HOLD / DROP
  - hold buffer `HoldInstr`
  - IF/ID register
- At most one outstanding request.
- "deliver" = instruction presented to IF/ID this cycle with `StallDecode`=0, `StallFetch`=0 and `PCSrcE`=0.
- IDLE: `imem_req_valid`=~`PCSrcE`, addr=`PCF`. Accepted (valid&ready) → WAIT; otherwise stay.
- WAIT:
  - `resp_valid` and deliver: load IF/ID with `{resp_data, PCF, PCF+4}`, `ValidD`=1, `PCF`←`PCF+4`.
    - In the same cycle issue the next request, addr=`PCF+4`.
    - Accepted → WAIT, else IDLE.
  - `resp_valid` and stalled (no redirect): `HoldInstr`←data, → HOLD.
  - No response: stay.
- HOLD: no request. When stalls clear, deliver `HoldInstr`, `PCF`←`PCF+4`, → IDLE.
- DROP: no request. Next `resp_valid` is discarded → IDLE.
- Redirect (`PCSrcE`=1), any state: `PCF`←`PCTargetE`, no delivery, no request issued this cycle.
  - WAIT without response → DROP.
  - WAIT with response → response discarded, → IDLE.
  - HOLD → buffer discarded, → IDLE.
  - DROP → stays DROP.
- A request may be withdrawn before acceptance (valid drops on redirect); memory must not rely on valid persistence.
- IF/ID priority:
  - `FlushDecode` → bubble.
  - else `StallDecode` → hold.
  - else deliver → load.
  - else → bubble.
  - Bubble: `InstrD`=NOP 32'h0000_0013, `PCD`=0, `PCPlus4D`=0, `ValidD`=0.
- PC arithmetic is modulo 2^ADDRESS_WIDTH; wrap from 0xFFFF_FFFC to 0 is silent.

## Timing
- Reset (async, takes effect immediately without a clock edge):
  - `PCF`=`RESET_PC`, state=IDLE, IF/ID=bubble, `HoldInstr`=0.
  - `imem_req_valid`=1 with addr=`RESET_PC` while `rst`=0 and IDLE.
  - During `rst`=1, `imem_req_valid`=0.
- Memory shares `rst`; in-flight responses are killed by reset.
- Latency: request accepted in cycle N, response in N+k (k≥1), `InstrD` valid from the edge ending N+k.
- Throughput: one instruction per cycle with k=1 and `ready`=1.
- Redirect in cycle N: first correct-path request issued in N+1 if not DROP. Until the first target instruction arrives, decode sees bubbles.
- Combinational paths: `imem_req_valid`/`addr` depend on state, `PCF`, `resp_valid`, stalls and `PCSrcE`. No other combinational input→output path.

## Structure
- Shared package `pipeline_pkg`:
  - `fetch_state_t` enum (IDLE, WAIT, HOLD, DROP)
  - `NOP_INSTR` = 32'h0000_0013
  - `PC_STEP` = 4
- One sub-module `if_id_reg`: IF/ID register with flush/stall/load/bubble priority, parameterised by `ADDRESS_WIDTH`/`DATA_WIDTH`.

## Test plan
1. Assert `rst` mid-cycle while in HOLD → outputs go to bubble immediately without a clock edge. After release: `imem_req_valid`=1, addr=0x0, `ValidD`=0, `InstrD`=0x13.
2. `ready`=1, k=1, memory returns addr-derived data → `PCD`=0x0, 0x4, 0x8, 0xC on consecutive cycles, `ValidD`=1 throughout.
3. `StallDecode`=`StallFetch`=1 when the response for 0x8 arrives → HOLD, `InstrD` unchanged. Release two cycles later → `PCD`=0x8, then request 0xC issued.
4. k=3, `PCSrcE`=1 with target 0x100 one cycle after acceptance of 0x10 → DROP. Stale response discarded, next request addr=0x100, `PCD`=0x100 with no 0x10 delivery.
5. `FlushDecode`=1 and `StallDecode`=1 together → `ValidD`=0, `InstrD`=0x13, `PCD`=0.
6. `ready`=0 for 4 cycles in IDLE → `imem_req_valid` held with addr stable, `ValidD`=0. Then `PCSrcE` with target 0x40 → addr becomes 0x40 next cycle.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions.
//   fetch_state_t : fetch sequencer states
//   NOP_INSTR     : canonical bubble instruction (addi x0, x0, 0)
//   PC_STEP       : sequential PC increment in bytes
package pipeline_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD,
        DROP
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int unsigned PC_STEP   = 4;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk_i, rst_i       : clock, asynchronous active-high reset
//   flush_i            : insert a bubble (highest priority)
//   stall_i            : hold current contents
//   load_i             : capture instr_i / pc_i
//   instr_i, pc_i      : instruction and its PC from fetch
//   instr_o, pc_o      : registered instruction / PC
//   pc_plus4_o         : registered PC + 4
//   valid_o            : contents are a real instruction
module if_id_reg
    import pipeline_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     stall_i,
    input  logic                     load_i,
    input  logic [DATA_WIDTH-1:0]    instr_i,
    input  logic [ADDRESS_WIDTH-1:0] pc_i,
    output logic [DATA_WIDTH-1:0]    instr_o,
    output logic [ADDRESS_WIDTH-1:0] pc_o,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4_o,
    output logic                     valid_o
);

    logic [DATA_WIDTH-1:0]    instr_q;
    logic [ADDRESS_WIDTH-1:0] pc_q;
    logic [ADDRESS_WIDTH-1:0] pc_plus4_q;
    logic                     valid_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            instr_q    <= DATA_WIDTH'(NOP_INSTR);
            pc_q       <= '0;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else if (flush_i || (!stall_i && !load_i)) begin
            instr_q    <= DATA_WIDTH'(NOP_INSTR);
            pc_q       <= '0;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else if (!stall_i) begin
            instr_q    <= instr_i;
            pc_q       <= pc_i;
            pc_plus4_q <= pc_i + ADDRESS_WIDTH'(PC_STEP);
            valid_q    <= 1'b1;
        end
    end

    assign instr_o    = instr_q;
    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, keeps at most one request outstanding to
// instruction memory, and feeds the IF/ID register without ever delivering a wrong-path
// instruction after a redirect.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   StallFetch / StallDecode      : hazard-unit stalls
//   FlushDecode                   : bubble the IF/ID register
//   PCSrcE / PCTargetE            : redirect from execute
//   imem_req_valid/addr/ready     : request channel (valid may be withdrawn)
//   imem_resp_valid/data          : in-order response, >= 1 cycle after acceptance
//   InstrD / PCD / PCPlus4D / ValidD : IF/ID register outputs
module fetch_unit
    import pipeline_pkg::*;
#(
    parameter int unsigned              ADDRESS_WIDTH = 32,
    parameter int unsigned              DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     StallFetch,
    input  logic                     StallDecode,
    input  logic                     FlushDecode,
    input  logic                     PCSrcE,
    input  logic [ADDRESS_WIDTH-1:0] PCTargetE,
    output logic                     imem_req_valid,
    output logic [ADDRESS_WIDTH-1:0] imem_req_addr,
    input  logic                     imem_req_ready,
    input  logic                     imem_resp_valid,
    input  logic [DATA_WIDTH-1:0]    imem_resp_data,
    output logic [DATA_WIDTH-1:0]    InstrD,
    output logic [ADDRESS_WIDTH-1:0] PCD,
    output logic [ADDRESS_WIDTH-1:0] PCPlus4D,
    output logic                     ValidD
);

    fetch_state_t             state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0]    hold_q, hold_d;

    logic                     req_valid;
    logic [ADDRESS_WIDTH-1:0] req_addr;
    logic                     load;
    logic [DATA_WIDTH-1:0]    load_instr;
    logic [ADDRESS_WIDTH-1:0] pc_plus4;
    logic                     no_stall;

    assign pc_plus4 = pc_q + ADDRESS_WIDTH'(PC_STEP);
    assign no_stall = !StallFetch && !StallDecode;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        hold_d     = hold_q;
        req_valid  = 1'b0;
        req_addr   = pc_q;
        load       = 1'b0;
        load_instr = hold_q;

        unique case (state_q)
            IDLE: begin
                req_valid = !PCSrcE;
                if (req_valid && imem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (PCSrcE) begin
                    // A response arriving with the redirect is simply dropped; otherwise the
                    // stale response is still in flight and must be swallowed later.
                    state_d = imem_resp_valid ? IDLE : DROP;
                end else if (imem_resp_valid && no_stall) begin
                    load       = 1'b1;
                    load_instr = imem_resp_data;
                    pc_d       = pc_plus4;
                    // Back-to-back issue keeps one instruction per cycle at k=1.
                    req_valid  = 1'b1;
                    req_addr   = pc_plus4;
                    state_d    = imem_req_ready ? WAIT : IDLE;
                end else if (imem_resp_valid) begin
                    hold_d  = imem_resp_data;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (PCSrcE) begin
                    state_d = IDLE;
                end else if (no_stall) begin
                    load    = 1'b1;
                    pc_d    = pc_plus4;
                    state_d = IDLE;
                end
            end
            DROP: begin
                // The stale response leaves DROP even if a further redirect lands in the
                // same cycle, otherwise nothing would ever arrive to release us.
                if (imem_resp_valid) begin
                    state_d = IDLE;
                end
            end
        endcase

        if (PCSrcE) begin
            pc_d = PCTargetE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
        end
    end

    assign imem_req_valid = req_valid && !rst;
    assign imem_req_addr  = req_addr;

    if_id_reg #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .DATA_WIDTH   (DATA_WIDTH)
    ) u_if_id_reg (
        .clk_i     (clk),
        .rst_i     (rst),
        .flush_i   (FlushDecode),
        .stall_i   (StallDecode),
        .load_i    (load),
        .instr_i   (load_instr),
        .pc_i      (pc_q),
        .instr_o   (InstrD),
        .pc_o      (PCD),
        .pc_plus4_o(PCPlus4D),
        .valid_o   (ValidD)
    );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        StallFetch, StallDecode, FlushDecode, PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    // Memory model: one outstanding request, latency mem_lat (>= 1).
    logic        mem_ready;
    int          mem_lat;
    logic        mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .StallFetch     (StallFetch),
        .StallDecode    (StallDecode),
        .FlushDecode    (FlushDecode),
        .PCSrcE         (PCSrcE),
        .PCTargetE      (PCTargetE),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .InstrD         (InstrD),
        .PCD            (PCD),
        .PCPlus4D       (PCPlus4D),
        .ValidD         (ValidD)
    );

    always #5 clk = ~clk;

    assign imem_req_ready  = mem_ready;
    assign imem_resp_valid = mem_busy && (mem_cnt == 0);
    assign imem_resp_data  = imem_resp_valid ? data_of(mem_addr) : 32'hDEAD_BEEF;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_busy <= 1'b0;
            mem_cnt  <= 0;
            mem_addr <= '0;
        end else if (imem_req_valid && mem_ready) begin
            mem_busy <= 1'b1;
            mem_cnt  <= mem_lat - 1;
            mem_addr <= imem_req_addr;
        end else if (imem_resp_valid) begin
            mem_busy <= 1'b0;
        end else if (mem_busy) begin
            mem_cnt <= mem_cnt - 1;
        end
    end

    // Scoreboard: every edge that loads IF/ID (StallDecode low, ValidD high after) pops one
    // expected PC and checks the whole IF/ID contents.
    initial begin
        logic        sd;
        logic [31:0] e;
        forever begin
            @(posedge clk);
            sd = StallDecode;
            @(negedge clk);
            if (!rst && ValidD && !sd) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL delivery: unexpected PCD=%h InstrD=%h, none required", PCD, InstrD);
                end else begin
                    e = exp_q.pop_front();
                    if ({PCD, InstrD, PCPlus4D} !== {e, data_of(e), e + 32'd4}) begin
                        n_fail++;
                        $display("FAIL delivery: got PCD=%h InstrD=%h PCPlus4D=%h, required %h %h %h",
                                 PCD, InstrD, PCPlus4D, e, data_of(e), e + 32'd4);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        StallFetch = 1'b0; StallDecode = 1'b0; FlushDecode = 1'b0;
        PCSrcE = 1'b0; PCTargetE = '0;
        mem_ready = 1'b1; mem_lat = 1;
        tick();
        exp_q.delete();
        rst = 1'b0;
        #1;
    endtask

    task automatic check_q_empty(input string name);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d deliveries outstanding, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        StallFetch = 1'b0; StallDecode = 1'b0; FlushDecode = 1'b0;
        PCSrcE = 1'b0; PCTargetE = '0;
        mem_ready = 1'b1; mem_lat = 1;
        #2;
        n_checks++;
        if ({imem_req_valid, ValidD, InstrD, PCD} !== {1'b0, 1'b0, 32'h13, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_hold: got req_valid=%b ValidD=%b InstrD=%h PCD=%h, required 0 0 13 0",
                     imem_req_valid, ValidD, InstrD, PCD);
        end
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_release: got req_valid=%b addr=%h, required 1 0",
                     imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_stream();
        apply_reset();
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        exp_q.push_back(32'h8); exp_q.push_back(32'hC);
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            mid();
            n_checks++;
            if (ValidD !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_valid[%0d]: got ValidD=%b, required 1", i, ValidD);
            end
        end
        check_q_empty("stream_done");
    endtask

    task automatic test_stall_hold();
        apply_reset();
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        exp_q.push_back(32'h8); exp_q.push_back(32'hC);
        tick(); tick(); tick();
        StallDecode = 1'b1; StallFetch = 1'b1;
        tick();
        mid();
        n_checks++;
        if ({ValidD, PCD, InstrD, imem_req_valid} !== {1'b1, 32'h4, data_of(32'h4), 1'b0}) begin
            n_fail++;
            $display("FAIL stall_hold: got ValidD=%b PCD=%h InstrD=%h req=%b, required 1 4 %h 0",
                     ValidD, PCD, InstrD, imem_req_valid, data_of(32'h4));
        end
        tick();
        StallDecode = 1'b0; StallFetch = 1'b0;
        #1;
        n_checks++;
        if (imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_no_req: got req_valid=%b, required 0", imem_req_valid);
        end
        tick();
        n_checks++;
        if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'hC}) begin
            n_fail++;
            $display("FAIL hold_next_req: got req_valid=%b addr=%h, required 1 C",
                     imem_req_valid, imem_req_addr);
        end
        tick(); tick();
        mid();
        check_q_empty("stall_done");
    endtask

    task automatic test_redirect_drop();
        apply_reset();
        exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
        exp_q.push_back(32'hC); exp_q.push_back(32'h100);
        for (int i = 0; i < 4; i++) tick();
        mem_lat = 3;
        tick();
        PCSrcE = 1'b1; PCTargetE = 32'h100;
        #1;
        n_checks++;
        if (imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redirect_no_req: got req_valid=%b, required 0", imem_req_valid);
        end
        tick();
        PCSrcE = 1'b0;
        #1;
        n_checks++;
        if ({imem_req_valid, ValidD} !== 2'b00) begin
            n_fail++;
            $display("FAIL drop_state: got req_valid=%b ValidD=%b, required 0 0",
                     imem_req_valid, ValidD);
        end
        tick(); tick();
        n_checks++;
        if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h100}) begin
            n_fail++;
            $display("FAIL drop_target_req: got req_valid=%b addr=%h, required 1 100",
                     imem_req_valid, imem_req_addr);
        end
        tick();
        mid();
        n_checks++;
        if (ValidD !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_bubble: got ValidD=%b, required 0", ValidD);
        end
        tick(); tick(); tick();
        mid();
        check_q_empty("drop_done");
    endtask

    task automatic test_flush();
        apply_reset();
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        tick(); tick();
        FlushDecode = 1'b1; StallDecode = 1'b1;
        tick();
        FlushDecode = 1'b0; StallDecode = 1'b0;
        mid();
        n_checks++;
        if ({ValidD, InstrD, PCD, PCPlus4D} !== {1'b0, 32'h13, 32'h0, 32'h0}) begin
            n_fail++;
            $display("FAIL flush_bubble: got ValidD=%b InstrD=%h PCD=%h PCPlus4D=%h, required 0 13 0 0",
                     ValidD, InstrD, PCD, PCPlus4D);
        end
        tick();
        mid();
        check_q_empty("flush_done");
    endtask

    task automatic test_ready_low();
        apply_reset();
        mem_ready = 1'b0;
        exp_q.push_back(32'h40);
        for (int i = 0; i < 4; i++) begin
            mid();
            n_checks++;
            if ({imem_req_valid, imem_req_addr, ValidD} !== {1'b1, 32'h0, 1'b0}) begin
                n_fail++;
                $display("FAIL ready_low[%0d]: got req=%b addr=%h ValidD=%b, required 1 0 0",
                         i, imem_req_valid, imem_req_addr, ValidD);
            end
            tick();
        end
        PCSrcE = 1'b1; PCTargetE = 32'h40;
        #1;
        n_checks++;
        if (imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_redirect_withdraw: got req_valid=%b, required 0", imem_req_valid);
        end
        tick();
        PCSrcE = 1'b0; mem_ready = 1'b1;
        #1;
        n_checks++;
        if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h40}) begin
            n_fail++;
            $display("FAIL ready_target_req: got req_valid=%b addr=%h, required 1 40",
                     imem_req_valid, imem_req_addr);
        end
        tick(); tick();
        mid();
        check_q_empty("ready_done");
    endtask

    task automatic test_reset_in_hold();
        apply_reset();
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        tick(); tick();
        StallDecode = 1'b1; StallFetch = 1'b1;
        tick();
        mid();
        n_checks++;
        if ({ValidD, PCD, exp_q.size() == 1} !== {1'b1, 32'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL hold_before_reset: got ValidD=%b PCD=%h pending=%0d, required 1 0 1",
                     ValidD, PCD, exp_q.size());
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({ValidD, InstrD, PCD, imem_req_valid} !== {1'b0, 32'h13, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset: got ValidD=%b InstrD=%h PCD=%h req=%b, required 0 13 0 0",
                     ValidD, InstrD, PCD, imem_req_valid);
        end
        StallDecode = 1'b0; StallFetch = 1'b0;
        exp_q.delete();
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if ({imem_req_valid, imem_req_addr, ValidD, InstrD} !== {1'b1, 32'h0, 1'b0, 32'h13}) begin
            n_fail++;
            $display("FAIL after_reset: got req=%b addr=%h ValidD=%b InstrD=%h, required 1 0 0 13",
                     imem_req_valid, imem_req_addr, ValidD, InstrD);
        end
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall_hold();
        test_redirect_drop();
        test_flush();
        test_ready_low();
        test_reset_in_hold();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
